// File: rtl/stopwatch_timebase_pkg.sv
// Shared definitions for the stopwatch timebase: FSM encoding, key indices
// and the default board clock.
package stopwatch_timebase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEFAULT_CLK_HZ = 50_000_000;

  localparam int NUM_KEYS = 2;
  localparam int KEY_RUN_IDX = 0;
  localparam int KEY_CLR_IDX = 1;

endpackage

// File: rtl/stopwatch_timebase_key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter, and a
// one-cycle press event on the accepted 1->0 transition of the level.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          accept;

  // The synchronized level must disagree with the accepted level for
  // DEB_CYCLES consecutive cycles before it is taken over.
  assign accept = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        if (accept) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
      press_reg <= accept && !sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: run/pause/clear FSM driven by two debounced keys, plus
// the prescaler that issues the hundredths enable pulse while running.
module stopwatch_timebase
  import stopwatch_timebase_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       KEY_run,
  input  logic       KEY_clr,
  output logic       tick,
  output logic       hold,
  output logic       clear,
  output logic [1:0] state_dbg
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [NUM_KEYS-1:0] key_bus;
  logic [NUM_KEYS-1:0] press_bus;
  logic                run_evt;
  logic                clr_evt;

  assign key_bus = {KEY_clr, KEY_run};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .Clock (Clock),
      .Resetn(Resetn),
      .key_n (key_bus[gi]),
      .press (press_bus[gi])
    );
  end

  assign run_evt = press_bus[KEY_RUN_IDX];
  assign clr_evt = press_bus[KEY_CLR_IDX];

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic          wrap;
  logic          tick_reg;
  logic          tick_next;
  logic          hold_reg;
  logic          hold_next;
  logic          clear_reg;
  logic          clear_next;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // run_evt has priority, so a simultaneous clear is simply dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (run_evt) state_next = ST_RUN;
      ST_RUN:   if (run_evt) state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (run_evt)      state_next = ST_RUN;
        else if (clr_evt) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wrap       = (state_reg == ST_RUN) && (presc_reg == PRE_LAST);
    hold_next  = (state_reg == ST_RUN);
    tick_next  = wrap;
    clear_next = clr_evt && !run_evt && (state_reg != ST_RUN);
    if (state_next == ST_IDLE) begin
      presc_next = '0;
    end else if (state_reg == ST_RUN) begin
      presc_next = wrap ? '0 : presc_reg + 1'b1;
    end else begin
      presc_next = presc_reg;
    end
  end

  // hold and tick both trail the state by one cycle, keeping tick inside
  // the hold window even when a pause lands on the wrap cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      hold_reg  <= 1'b0;
      clear_reg <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      tick_reg  <= tick_next;
      hold_reg  <= hold_next;
      clear_reg <= clear_next;
    end
  end

  assign tick      = tick_reg;
  assign hold      = hold_reg;
  assign clear     = clear_reg;
  assign state_dbg = state_reg;

endmodule
